// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register feeding the EX-stage ALU.
// Captures a decoded instruction on each posedge and translates ALUOp/funct
// into the 3-bit ALU control code. Operands pass through combinational
// EX/MEM and MEM/WB forwarding muxes so that they settle before the ALU
// samples them at negedge.
//
// Ports:
//   clk, reset           pipeline clock, synchronous active-high reset
//   id_valid             ID holds a real instruction
//   stall, flush         hold stage / load bubble (flush wins)
//   id_alu_op, id_funct  ALUOp (00 add, 01 sub, 10 funct, 11 reserved), funct
//   id_alu_src           1: B = immediate, 0: B = rt
//   id_rs_data, id_rt_data, id_imm, id_rs, id_rt   operands and source regs
//   exmem_*, memwb_*     writeback enable, destination and value of later stages
//   alu_control          registered ALU code
//   alu_a, alu_b         forwarded ALU operands
//   ex_store_data        forwarded rt value for stores
//   ex_valid, ex_illegal registered valid / illegal-op flags
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              exmem_reg_write,
  input  logic              memwb_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_illegal
);

  logic [2:0]        dec_ctrl;
  logic              dec_ill;

  logic              ex_alu_src;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;

  // ALUOp/funct translation to ALU control code
  always_comb begin
    dec_ctrl = 3'b010;
    dec_ill  = 1'b0;
    case (id_alu_op)
      2'b00: dec_ctrl = 3'b010;
      2'b01: dec_ctrl = 3'b110;
      2'b10: begin
        case (id_funct)
          6'b100000: dec_ctrl = 3'b010;
          6'b100010: dec_ctrl = 3'b110;
          6'b100100: dec_ctrl = 3'b000;
          6'b100101: dec_ctrl = 3'b001;
          6'b101010: dec_ctrl = 3'b111;
          default: begin
            dec_ctrl = 3'b011;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl = 3'b011;
        dec_ill  = 1'b1;
      end
    endcase
  end

  // A load of an invalid ID slot is folded into the bubble case; a stall
  // only holds when neither reset nor flush is active.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !id_valid)) begin
      ex_valid    <= 1'b0;
      alu_control <= 3'b010;
      ex_illegal  <= 1'b0;
      ex_alu_src  <= 1'b0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
    end else if (!stall) begin
      ex_valid    <= 1'b1;
      alu_control <= dec_ctrl;
      ex_illegal  <= dec_ill;
      ex_alu_src  <= id_alu_src;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
    end
  end

  // Forwarding: EX/MEM has priority over MEM/WB; register 0 never forwards.
  always_comb begin
    alu_a = ex_rs_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs))
      alu_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs))
      alu_a = memwb_result;
  end

  always_comb begin
    ex_store_data = ex_rt_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt))
      ex_store_data = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt))
      ex_store_data = memwb_result;
  end

  assign alu_b = ex_alu_src ? ex_imm : ex_store_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall, flush;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [2:0]  alu_control;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic        ex_valid, ex_illegal;

  int checks = 0;
  int errors = 0;

  // reference model: the instruction currently held in EX
  logic        m_valid, m_ill, m_src;
  logic [2:0]  m_ctrl;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt;

  logic [5:0]  functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0]  codes  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Table lookup of the ALU code; anything not in the table is illegal.
  task automatic ref_decode(input logic [1:0] op, input logic [5:0] fn,
                            output logic [2:0] code, output logic ill);
    code = 3'b011;
    ill  = 1'b1;
    if (op == 2'd0) begin code = 3'b010; ill = 1'b0; end
    if (op == 2'd1) begin code = 3'b110; ill = 1'b0; end
    if (op == 2'd2)
      for (int i = 0; i < 5; i++)
        if (functs[i] == fn) begin code = codes[i]; ill = 1'b0; end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return d;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [2:0] c;
    logic       il;
    ref_decode(id_alu_op, id_funct, c, il);
    if (reset || flush || (!stall && !id_valid)) begin
      m_valid = 0; m_ctrl = 3'b010; m_ill = 0; m_src = 0;
      m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_rs = 0; m_rt = 0;
    end else if (!stall) begin
      m_valid = 1; m_ctrl = c; m_ill = il; m_src = id_alu_src;
      m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] st;
    st = ref_fwd(m_rt, m_rt_data);
    check({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    check({tag, ".ctrl"},  32'(alu_control), 32'(m_ctrl));
    check({tag, ".ill"},   32'(ex_illegal), 32'(m_ill));
    check({tag, ".a"},     alu_a, ref_fwd(m_rs, m_rs_data));
    check({tag, ".store"}, ex_store_data, st);
    check({tag, ".b"},     alu_b, m_src ? m_imm : st);
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_alu_op = 2'($urandom); id_funct = 6'($urandom);
    id_alu_src = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
  endtask

  task automatic rand_late();
    exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
    exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
    exmem_result = $urandom; memwb_result = $urandom;
  endtask

  initial begin
    logic [2:0]  s_ctrl;
    logic [31:0] s_a, s_b;
    m_valid = 1'bx;
    reset = 1; stall = 0; flush = 0;
    rand_id(); rand_late();

    // reset with random inputs for two cycles
    tick(); rand_id(); rand_late();
    tick();
    check("rst.valid", 32'(ex_valid), 0);
    check("rst.ctrl", 32'(alu_control), 32'(3'b010));
    check("rst.ill", 32'(ex_illegal), 0);
    check("rst.a", alu_a, 0);
    check("rst.b", alu_b, 0);
    check("rst.store", ex_store_data, 0);

    // decode sweep
    reset = 0; id_valid = 1; exmem_reg_write = 0; memwb_reg_write = 0;
    for (int i = 0; i < 5; i++) begin
      id_alu_op = 2'd2; id_funct = functs[i];
      tick();
      check($sformatf("dec.f%0h", functs[i]), 32'(alu_control), 32'(codes[i]));
      check($sformatf("dec.f%0h.ill", functs[i]), 32'(ex_illegal), 0);
    end
    id_funct = 6'h27; tick();
    check("dec.f27", 32'(alu_control), 32'(3'b011));
    check("dec.f27.ill", 32'(ex_illegal), 1);
    id_alu_op = 2'd0; tick(); check("dec.op0", 32'(alu_control), 32'(3'b010));
    id_alu_op = 2'd1; tick(); check("dec.op1", 32'(alu_control), 32'(3'b110));
    id_alu_op = 2'd3; tick(); check("dec.op3", 32'(alu_control), 32'(3'b011));
    check("dec.op3.ill", 32'(ex_illegal), 1);
    check_all("dec");

    // forward priority on A
    id_alu_op = 0; id_rs = 5; id_rs_data = 1; id_rt = 9; id_alu_src = 0;
    tick();
    exmem_rd = 5; exmem_result = 32'hAAAA; memwb_rd = 5; memwb_result = 32'hBBBB;
    exmem_reg_write = 1; memwb_reg_write = 1; #1;
    check("fwd.exmem", alu_a, 32'hAAAA);
    exmem_reg_write = 0; #1;
    check("fwd.memwb", alu_a, 32'hBBBB);
    memwb_reg_write = 0; #1;
    check("fwd.none", alu_a, 1);

    // register 0 is never forwarded
    id_rt = 0; id_rt_data = 7; id_alu_src = 0;
    tick();
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFFFF; #1;
    check("r0.b", alu_b, 7);
    check("r0.store", ex_store_data, 7);

    // immediate select, rt still forwarded to store data
    id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_rt = 3; id_rt_data = 0;
    tick();
    exmem_rd = 3; exmem_result = 32'h10; #1;
    check("imm.b", alu_b, 32'hFFFFFFFC);
    check("imm.store", ex_store_data, 32'h10);

    // stall holds for three cycles
    exmem_reg_write = 0; memwb_reg_write = 0;
    id_alu_op = 0; id_alu_src = 0; id_rs = 1; id_rt = 2;
    id_rs_data = 32'h1234; id_rt_data = 32'h5678;
    tick();
    s_ctrl = alu_control; s_a = alu_a; s_b = alu_b;
    check("ld.a", alu_a, 32'h1234);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); id_valid = 1;
      tick();
      check($sformatf("stall%0d.ctrl", i), 32'(alu_control), 32'(s_ctrl));
      check($sformatf("stall%0d.a", i), alu_a, s_a);
      check($sformatf("stall%0d.b", i), alu_b, s_b);
      check($sformatf("stall%0d.valid", i), 32'(ex_valid), 1);
    end
    // stall with invalid ID still holds
    id_valid = 0; tick();
    check("stallinv.valid", 32'(ex_valid), 1);

    // flush overrides stall
    flush = 1; id_valid = 1; id_alu_op = 1; tick();
    check("flush.valid", 32'(ex_valid), 0);
    check("flush.ctrl", 32'(alu_control), 32'(3'b010));
    check_all("flush");
    flush = 0; stall = 0;

    // randomized stream against the model
    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 19) == 0);
      tick();
      rand_late(); #1;
      check_all($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that feeds the EX-stage ALU. On each rising clock edge it captures a decoded instruction from ID, translates the 2-bit ALUOp/funct pair into the 3-bit ALU control code, and registers operands. Combinational forwarding muxes then present `alu_a`/`alu_b` early enough for the ALU's falling-edge evaluation. It supports stall, flush and bubble insertion, so it is the producer end of the ALU's control/operand interface.

## Interface
- `DATA_W`, 32, operand/result width
- `clk`  in  1  pipeline clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `id_valid`  in  1  ID holds a real instruction
- `stall`  in  1  hold all stage registers
- `flush`  in  1  load a bubble (overrides `stall`)
- `id_alu_op`  in  2  00 add, 01 sub, 10 decode funct, 11 reserved
- `id_funct`  in  6  instruction funct field
- `id_alu_src`  in  1  1: B = immediate, 0: B = rt
- `id_rs_data`, `id_rt_data`, `id_imm`  in  DATA_W  register operands, sign-extended immediate
- `id_rs`, `id_rt`  in  5  source register numbers
- `exmem_reg_write`, `memwb_reg_write`  in  1  writeback enables of the later stages
- `exmem_rd`, `memwb_rd`  in  5  destination registers of the later stages
- `exmem_result`, `memwb_result`  in  DATA_W  forwardable values
- `alu_control`  out  3  registered ALU code
- `alu_a`, `alu_b`  out  DATA_W  forwarded ALU operands (combinational from registers)
- `ex_store_data`  out  DATA_W  forwarded rt value, for sw
- `ex_valid`  out  1  EX holds a real instruction
- `ex_illegal`  out  1  registered; ALUOp=10 with an unsupported funct, or ALUOp=11

## Operation
- Stage registers: valid, control, illegal, alu_src, rs_data, rt_data, imm, rs, rt.
- Register update priority at posedge: `reset` > `flush` > `stall` (hold) > load.
- Load with `id_valid`=0 behaves the same as a bubble.
- Bubble/reset contents:
  - valid=0, control=3'b010, illegal=0.
  - alu_src=0, all data registers 0, rs=rt=0.
- ALUOp 00 → 010, ALUOp 01 → 110.
- ALUOp 10, by funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Any other funct → 011, with illegal=1.
- ALUOp 11 → 011, with illegal=1.
- Forward for A, using registered rs:
  - If exmem_reg_write && exmem_rd≠0 && exmem_rd==rs: use `exmem_result`.
  - Else if the same test passes for memwb: use `memwb_result`.
  - Else: use registered rs_data.
- Forward for rt uses the same rule on registered rt and gives `ex_store_data`.
- `alu_b` = registered alu_src ? imm : `ex_store_data`.
- Register 0 is never forwarded. EX/MEM wins when both later stages match.
- Forwarding is applied even when ex_valid=0. Bubbles carry rs=rt=0, so they never match.

## Timing
- Latency: ID inputs appear on `alu_control`/`ex_valid`/`ex_illegal` one posedge later.
- Forward paths are combinational. `alu_a`/`alu_b` must settle within half a cycle, before the ALU samples at negedge.
- Reset values: `ex_valid`=0, `alu_control`=010, `ex_illegal`=0, `alu_a`=`alu_b`=`ex_store_data`=0.
  - These hold only while no forward source matches register 0; by rule none can.
- `stall` held N cycles: outputs stay constant for N cycles. Forwarded values still follow changes on the later-stage inputs.
- `flush` and `stall` asserted together: bubble loaded.
- Reset asserted mid-stream: bubble values on the next posedge, regardless of `stall`/`flush`.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs → `ex_valid`=0, `alu_control`=010, `alu_a`=`alu_b`=0, `ex_illegal`=0.
- Decode sweep:
  - ALUOp=10 with funct 20h/22h/24h/25h/2Ah → control 010/110/000/001/111 one cycle later.
  - funct 27h → 011 with `ex_illegal`=1.
  - ALUOp 00/01/11 → 010/110/011 (011 with `ex_illegal`=1).
- Forward priority:
  - rs=5, rs_data=1, exmem_rd=5 with result 0xAAAA, memwb_rd=5 with result 0xBBBB, both write enables set → `alu_a`=0xAAAA.
  - Drop exmem_reg_write → `alu_a`=0xBBBB.
  - Drop memwb_reg_write → `alu_a`=1.
- Register 0: rt=0, exmem_rd=0 with write enable set, result 0xFFFF, rt_data=7, alu_src=0 → `alu_b`=7, `ex_store_data`=7.
- Immediate: alu_src=1, imm=0xFFFFFFFC, rt forwarded as 0x10 → `alu_b`=0xFFFFFFFC, `ex_store_data`=0x10.
- Stall/flush:
  - Load an add, then hold `stall` 3 cycles with new ID inputs → outputs unchanged.
  - Assert `stall`+`flush` → next cycle `ex_valid`=0, `alu_control`=010.
